// File: rtl/trap_csr_unit_pkg.sv
// Shared encodings for the machine-mode CSR file and trap sequencer:
// privilege levels, CSR op codes, sequencer states, CSR addresses and mstatus bit positions.
package trap_csr_unit_pkg;

  typedef enum logic [1:0] {
    USER    = 2'd0,
    SUPERV  = 2'd1,
    MACHINE = 2'd3
  } priv_e;

  typedef enum logic [1:0] {
    CSR_WRITE = 2'd0,
    CSR_SET   = 2'd1,
    CSR_CLEAR = 2'd2,
    CSR_NONE  = 2'd3
  } csr_op_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } state_e;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [3:0] CAUSE_ILLEGAL_INSTR = 4'd2;

  function automatic logic csr_implemented(input logic [11:0] addr);
    return (addr == CSR_MSTATUS) || (addr == CSR_MTVEC) || (addr == CSR_MSCRATCH) ||
           (addr == CSR_MEPC) || (addr == CSR_MCAUSE);
  endfunction

endpackage

// File: rtl/trap_csr_unit_csr_alu.sv
// Combinational CSR write/set/clear with rs1/zimm operand select; zero latency, no flow control.
// wr_suppress_o flags accesses that must not update the CSR (op none, or set/clear with a zero operand).
module csr_alu
  import trap_csr_unit_pkg::*;
(
  input  logic [1:0]  csr_op_i,
  input  logic        csr_src_i,
  input  logic [31:0] rs1_val_i,
  input  logic [4:0]  zimm_i,
  input  logic [31:0] old_i,
  output logic [31:0] new_o,
  output logic        wr_suppress_o
);

  logic [31:0] operand;

  always_comb begin
    operand       = csr_src_i ? {27'b0, zimm_i} : rs1_val_i;
    new_o         = old_i;
    wr_suppress_o = 1'b0;
    case (csr_op_e'(csr_op_i))
      CSR_WRITE: new_o = operand;
      CSR_SET: begin
        new_o         = old_i | operand;
        wr_suppress_o = (operand == 32'b0);
      end
      CSR_CLEAR: begin
        new_o         = old_i & ~operand;
        wr_suppress_o = (operand == 32'b0);
      end
      default: wr_suppress_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/trap_csr_unit.sv
// Machine-mode CSR file and trap/return sequencer; CSR read is combinational, updates land on the accepting edge.
// An accepted trap or return raises redirect/busy for exactly one cycle, during which all inputs are ignored.
module trap_csr_unit
  import trap_csr_unit_pkg::*;
#(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [31:0] pc,
  input  logic        RaiseExcep,
  input  logic [3:0]  ExcepCode,
  input  logic        Ret,
  input  logic        WriteCsrIDe,
  input  logic [1:0]  CsrOp,
  input  logic        CsrSrc,
  input  logic [11:0] csr_addr,
  input  logic [31:0] rs1_val,
  input  logic [4:0]  zimm,
  output logic [31:0] csr_rdata,
  output logic [1:0]  mode,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  state_e      state_q;
  logic        redirect_q, busy_q;
  logic [31:0] redirect_pc_q;

  logic [1:0]  mode_q, mode_d;
  logic        mie_q, mie_d, mpie_q, mpie_d;
  logic [1:0]  mpp_q, mpp_d;
  logic [31:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d, mepc_q, mepc_d;
  logic [3:0]  mcause_q, mcause_d;

  logic        live, csr_ok, take_trap, take_ret, csr_access, csr_we, wr_suppress;
  logic [31:0] csr_wdata;
  logic [3:0]  trap_code;

  always_comb begin
    csr_rdata = 32'b0;
    case (csr_addr)
      CSR_MSTATUS: begin
        csr_rdata[MSTATUS_MIE]                   = mie_q;
        csr_rdata[MSTATUS_MPIE]                  = mpie_q;
        csr_rdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = mpp_q;
      end
      CSR_MTVEC:    csr_rdata = mtvec_q;
      CSR_MSCRATCH: csr_rdata = mscratch_q;
      CSR_MEPC:     csr_rdata = mepc_q;
      CSR_MCAUSE:   csr_rdata = {28'b0, mcause_q};
      default:      csr_rdata = 32'b0;
    endcase
  end

  csr_alu u_csr_alu (
    .csr_op_i      (CsrOp),
    .csr_src_i     (CsrSrc),
    .rs1_val_i     (rs1_val),
    .zimm_i        (zimm),
    .old_i         (csr_rdata),
    .new_o         (csr_wdata),
    .wr_suppress_o (wr_suppress)
  );

  // Illegal CSR access outranks Ret, so it folds into the trap path.
  assign live       = valid && (state_q == ST_IDLE);
  assign csr_ok     = csr_implemented(csr_addr) && (mode_q >= csr_addr[9:8]);
  assign take_trap  = live && (RaiseExcep || (WriteCsrIDe && !csr_ok));
  assign take_ret   = live && Ret && !take_trap;
  assign csr_access = live && WriteCsrIDe && !take_trap && !Ret;
  assign csr_we     = csr_access && !wr_suppress;
  assign trap_code  = RaiseExcep ? ExcepCode : CAUSE_ILLEGAL_INSTR;

  always_comb begin
    mode_d     = mode_q;
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mpp_d      = mpp_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    if (csr_we) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mie_d  = csr_wdata[MSTATUS_MIE];
          mpie_d = csr_wdata[MSTATUS_MPIE];
          // 2'b10 is a reserved privilege level; keep the previous MPP.
          if (csr_wdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] != 2'b10)
            mpp_d = csr_wdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
        end
        CSR_MTVEC:    mtvec_d    = {csr_wdata[31:2], 2'b00};
        CSR_MSCRATCH: mscratch_d = csr_wdata;
        CSR_MEPC:     mepc_d     = {csr_wdata[31:2], 2'b00};
        CSR_MCAUSE:   mcause_d   = csr_wdata[3:0];
        default: ;
      endcase
    end
    if (take_trap) begin
      mepc_d   = pc;
      mcause_d = trap_code;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
      mpp_d    = mode_q;
      mode_d   = MACHINE;
    end
    if (take_ret) begin
      mode_d = mpp_q;
      mie_d  = mpie_q;
      mpie_d = 1'b1;
      mpp_d  = USER;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= MACHINE;
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mpp_q      <= 2'b00;
      mtvec_q    <= {RESET_MTVEC[31:2], 2'b00};
      mscratch_q <= 32'b0;
      mepc_q     <= 32'b0;
      mcause_q   <= 4'b0;
    end else begin
      mode_q     <= mode_d;
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mpp_q      <= mpp_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      redirect_q    <= 1'b0;
      busy_q        <= 1'b0;
      redirect_pc_q <= 32'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (take_trap || take_ret) begin
            state_q       <= ST_REDIRECT;
            redirect_q    <= 1'b1;
            busy_q        <= 1'b1;
            redirect_pc_q <= take_trap ? mtvec_q : mepc_q;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          redirect_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign mode        = mode_q;
  assign redirect    = redirect_q;
  assign busy        = busy_q;
  assign redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_trap_csr_unit.sv
// Directed bench for trap_csr_unit: stimulus queues expected reads/redirects/status,
// a negedge monitor pops and compares whenever the DUT presents a read or a redirect.
module tb_trap_csr_unit;

  localparam int K_READ  = 0;
  localparam int K_REDIR = 1;
  localparam int K_STAT  = 2;

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [31:0] pc;
  logic        RaiseExcep;
  logic [3:0]  ExcepCode;
  logic        Ret;
  logic        WriteCsrIDe;
  logic [1:0]  CsrOp;
  logic        CsrSrc;
  logic [11:0] csr_addr;
  logic [31:0] rs1_val;
  logic [4:0]  zimm;
  logic [31:0] csr_rdata;
  logic [1:0]  mode;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        busy;
  logic        probe;

  typedef struct {
    int          kind;
    logic [31:0] val;
    logic [1:0]  md;
    logic        rb;
    int          id;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_id   = 0;

  trap_csr_unit #(.RESET_MTVEC(32'h0000_0100)) dut (
    .clk(clk), .rst(rst), .valid(valid), .pc(pc), .RaiseExcep(RaiseExcep),
    .ExcepCode(ExcepCode), .Ret(Ret), .WriteCsrIDe(WriteCsrIDe), .CsrOp(CsrOp),
    .CsrSrc(CsrSrc), .csr_addr(csr_addr), .rs1_val(rs1_val), .zimm(zimm),
    .csr_rdata(csr_rdata), .mode(mode), .redirect(redirect),
    .redirect_pc(redirect_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic push(input int kind, input logic [31:0] val, input logic [1:0] md, input logic rb);
    exp_t e;
    e.kind = kind; e.val = val; e.md = md; e.rb = rb; e.id = n_id;
    n_id++;
    q.push_back(e);
  endtask

  task automatic check(input string nm, input int id, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s#%0d: got 0x%08h, want 0x%08h", nm, id, act, want);
    end
  endtask

  task automatic pop(input int kind, input string nm, output exp_t e, output bit ok);
    ok = 1'b0;
    e.kind = -1; e.val = '0; e.md = '0; e.rb = 1'b0; e.id = -1;
    if (q.size() == 0 || q[0].kind != kind) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: unexpected event at %0t, got kind %0d, want kind %0d", nm, $time, kind,
               (q.size() == 0) ? -1 : q[0].kind);
    end else begin
      e  = q.pop_front();
      ok = 1'b1;
    end
  endtask

  initial begin : monitor
    exp_t e;
    bit   ok;
    forever begin
      @(negedge clk);
      if (probe) begin
        pop(K_STAT, "status", e, ok);
        if (ok) begin
          check("stat_mode", e.id, {30'b0, mode}, {30'b0, e.md});
          check("stat_redirect", e.id, {31'b0, redirect}, {31'b0, e.rb});
          check("stat_busy", e.id, {31'b0, busy}, {31'b0, e.rb});
          check("stat_redirect_pc", e.id, redirect_pc, e.val);
        end
      end
      if (valid && WriteCsrIDe && !busy) begin
        pop(K_READ, "read", e, ok);
        if (ok) check("csr_rdata", e.id, csr_rdata, e.val);
      end
      if (redirect) begin
        pop(K_REDIR, "redirect", e, ok);
        if (ok) begin
          check("redirect_pc", e.id, redirect_pc, e.val);
          check("redirect_mode", e.id, {30'b0, mode}, {30'b0, e.md});
          check("redirect_busy", e.id, {31'b0, busy}, 32'd1);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid = 1'b0; RaiseExcep = 1'b0; ExcepCode = 4'd0; Ret = 1'b0;
    WriteCsrIDe = 1'b0; CsrOp = 2'd3; CsrSrc = 1'b0; csr_addr = 12'h0;
    rs1_val = 32'h0; zimm = 5'h0; probe = 1'b0;
  endtask

  task automatic csr_acc(input logic [1:0] op, input logic src, input logic [11:0] addr,
                         input logic [31:0] rs1, input logic [4:0] zi, input logic [31:0] exp_rd);
    valid = 1'b1; WriteCsrIDe = 1'b1; CsrOp = op; CsrSrc = src;
    csr_addr = addr; rs1_val = rs1; zimm = zi;
    push(K_READ, exp_rd, 2'd0, 1'b0);
    cyc();
    idle();
  endtask

  task automatic rd(input logic [11:0] addr, input logic [31:0] exp_rd);
    csr_acc(2'd3, 1'b0, addr, 32'h0, 5'h0, exp_rd);
  endtask

  task automatic trap(input logic raise, input logic [3:0] code, input logic ret, input logic [31:0] p,
                      input bit hold, input logic [31:0] exp_pc, input logic [1:0] exp_md);
    valid = 1'b1; RaiseExcep = raise; ExcepCode = code; Ret = ret; pc = p;
    push(K_REDIR, exp_pc, exp_md, 1'b1);
    cyc();
    if (!hold) idle();
    cyc();
    idle();
  endtask

  task automatic acc_trap(input logic raise, input logic [3:0] code, input logic [1:0] op,
                          input logic [11:0] addr, input logic [31:0] rs1, input logic [31:0] p,
                          input logic [31:0] exp_rd, input logic [31:0] exp_pc);
    valid = 1'b1; WriteCsrIDe = 1'b1; CsrOp = op; CsrSrc = 1'b0; csr_addr = addr;
    rs1_val = rs1; RaiseExcep = raise; ExcepCode = code; pc = p;
    push(K_READ, exp_rd, 2'd0, 1'b0);
    push(K_REDIR, exp_pc, 2'd3, 1'b1);
    cyc();
    idle();
    cyc();
  endtask

  task automatic stat(input logic [1:0] md, input logic rb, input logic [31:0] rpc);
    probe = 1'b1;
    push(K_STAT, rpc, md, rb);
    cyc();
    probe = 1'b0;
  endtask

  initial begin : stimulus
    idle();
    pc  = 32'h0;
    rst = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    stat(2'd3, 1'b0, 32'h0);

    rd(A_MTVEC, 32'h0000_0100);
    csr_acc(2'd0, 1'b0, A_MSCRATCH, 32'hDEAD_BEEF, 5'h0, 32'h0);
    csr_acc(2'd1, 1'b1, A_MSCRATCH, 32'h0, 5'h0, 32'hDEAD_BEEF);
    rd(A_MSCRATCH, 32'hDEAD_BEEF);
    csr_acc(2'd2, 1'b0, A_MSCRATCH, 32'h0000_FFFF, 5'h0, 32'hDEAD_BEEF);
    rd(A_MSCRATCH, 32'hDEAD_0000);
    csr_acc(2'd1, 1'b1, A_MSCRATCH, 32'h0, 5'h1F, 32'hDEAD_0000);
    rd(A_MSCRATCH, 32'hDEAD_001F);

    // Only MIE, MPIE and MPP survive a full-ones write to mstatus.
    csr_acc(2'd0, 1'b0, A_MSTATUS, 32'hFFFF_FFFF, 5'h0, 32'h0);
    rd(A_MSTATUS, 32'h0000_1888);
    csr_acc(2'd0, 1'b0, A_MSTATUS, 32'h0000_0008, 5'h0, 32'h0000_1888);
    rd(A_MSTATUS, 32'h0000_0008);

    trap(1'b1, 4'd11, 1'b0, 32'h0000_2000, 1'b0, 32'h0000_0100, 2'd3);
    rd(A_MEPC, 32'h0000_2000);
    rd(A_MCAUSE, 32'h0000_000B);
    rd(A_MSTATUS, 32'h0000_1880);

    csr_acc(2'd0, 1'b0, A_MTVEC, 32'h0000_0403, 5'h0, 32'h0000_0100);
    rd(A_MTVEC, 32'h0000_0400);
    csr_acc(2'd0, 1'b0, A_MEPC, 32'h0000_3003, 5'h0, 32'h0000_2000);
    rd(A_MEPC, 32'h0000_3000);
    csr_acc(2'd0, 1'b0, A_MSTATUS, 32'h0000_0080, 5'h0, 32'h0000_1880);
    trap(1'b0, 4'd0, 1'b1, 32'h0000_2500, 1'b0, 32'h0000_3000, 2'd0);

    // User-mode mstatus write traps with cause 2; rdata still shows MIE=1, MPIE=1, MPP=0.
    acc_trap(1'b0, 4'd0, 2'd0, A_MSTATUS, 32'h0, 32'h0000_3000, 32'h0000_0088, 32'h0000_0400);
    rd(A_MSTATUS, 32'h0000_0080);
    rd(A_MCAUSE, 32'h0000_0002);
    rd(A_MEPC, 32'h0000_3000);

    acc_trap(1'b0, 4'd0, 2'd3, 12'h7C0, 32'h0, 32'h0000_4444, 32'h0, 32'h0000_0400);
    rd(A_MEPC, 32'h0000_4444);
    rd(A_MCAUSE, 32'h0000_0002);
    rd(A_MSTATUS, 32'h0000_1800);

    acc_trap(1'b1, 4'd4, 2'd0, A_MSCRATCH, 32'h0000_1234, 32'h0000_4800, 32'hDEAD_001F, 32'h0000_0400);
    rd(A_MSCRATCH, 32'hDEAD_001F);
    rd(A_MCAUSE, 32'h0000_0004);

    trap(1'b1, 4'd3, 1'b1, 32'h0000_5000, 1'b1, 32'h0000_0400, 2'd3);
    rd(A_MCAUSE, 32'h0000_0003);
    rd(A_MEPC, 32'h0000_5000);

    valid = 1'b0; RaiseExcep = 1'b1; Ret = 1'b1;
    cyc();
    idle();
    cyc();

    valid = 1'b1; RaiseExcep = 1'b1; ExcepCode = 4'd1; pc = 32'h0000_6000;
    push(K_REDIR, 32'h0000_0400, 2'd3, 1'b1);
    cyc();
    idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    stat(2'd3, 1'b0, 32'h0);
    rd(A_MSCRATCH, 32'h0);
    rd(A_MTVEC, 32'h0000_0100);
    rd(A_MEPC, 32'h0);
    rd(A_MCAUSE, 32'h0);
    rd(A_MSTATUS, 32'h0);

    repeat (3) cyc();
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
